// File: rtl/risc_mgmt_ext_arbiter.sv
// Arbitrates NUM_EXT custom extensions onto the single execute-stage slot:
// exclusive grant, multi-cycle exec, shared memory port, one registered writeback.
//
// state  | meaning
// IDLE   | no owner; accepts a single unambiguous claim
// EXEC   | owner executing; watchdog counting
// MEM    | owner's memory transaction on the core port
// COMMIT | one-cycle writeback of the owner's result
module risc_mgmt_ext_arbiter #(
  parameter int NUM_EXT = 4,
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      insn_valid,
  input  logic                      flush,
  input  logic [NUM_EXT-1:0]        ext_claim,
  input  logic [NUM_EXT-1:0]        ext_done,
  input  logic [NUM_EXT-1:0]        ext_reg_w,
  input  logic [5*NUM_EXT-1:0]      ext_rd,
  input  logic [WORD_W*NUM_EXT-1:0] ext_wdata,
  input  logic [NUM_EXT-1:0]        ext_mem_req,
  input  logic [NUM_EXT-1:0]        ext_mem_wen,
  input  logic [WORD_W*NUM_EXT-1:0] ext_mem_addr,
  input  logic [WORD_W*NUM_EXT-1:0] ext_mem_store,
  input  logic                      mem_busy,
  input  logic [WORD_W-1:0]         mem_load,
  output logic [NUM_EXT-1:0]        grant,
  output logic                      active_insn,
  output logic                      execute_stall,
  output logic                      mem_ren,
  output logic                      mem_wen,
  output logic [WORD_W-1:0]         mem_addr,
  output logic [WORD_W-1:0]         mem_store,
  output logic [WORD_W-1:0]         ext_mem_load,
  output logic [NUM_EXT-1:0]        ext_mem_ack,
  output logic                      reg_w,
  output logic [4:0]                rsel_d,
  output logic [WORD_W-1:0]         reg_wdata,
  output logic                      exception,
  output logic [NUM_EXT-1:0]        ex_cause,
  output logic                      timeout
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXEC   = 2'd1;
  localparam logic [1:0] S_MEM    = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]         state_q, state_d;
  logic [NUM_EXT-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               regw_q, regw_d;
  logic [4:0]         rd_q, rd_d;
  logic [WORD_W-1:0]  wdata_q, wdata_d;
  logic               wen_q, wen_d;
  logic [WORD_W-1:0]  addr_q, addr_d;
  logic [WORD_W-1:0]  store_q, store_d;
  logic               flush_pend_q, flush_pend_d;
  logic [WORD_W-1:0]  ext_mem_load_q, ext_mem_load_d;
  logic [NUM_EXT-1:0] ack_q, ack_d;

  logic               own_done, own_mem_req, own_reg_w, own_mem_wen;
  logic [4:0]         own_rd;
  logic [WORD_W-1:0]  own_wdata, own_addr, own_store;
  logic               claim_one, claim_multi;

  // grant_q is one-hot (or zero), so an OR of masked lanes selects the owner
  always_comb begin
    own_rd    = '0;
    own_wdata = '0;
    own_addr  = '0;
    own_store = '0;
    for (int i = 0; i < NUM_EXT; i++) begin
      if (grant_q[i]) begin
        own_rd    = own_rd    | ext_rd[i*5 +: 5];
        own_wdata = own_wdata | ext_wdata[i*WORD_W +: WORD_W];
        own_addr  = own_addr  | ext_mem_addr[i*WORD_W +: WORD_W];
        own_store = own_store | ext_mem_store[i*WORD_W +: WORD_W];
      end
    end
  end

  assign own_done    = |(ext_done & grant_q);
  assign own_mem_req = |(ext_mem_req & grant_q);
  assign own_reg_w   = |(ext_reg_w & grant_q);
  assign own_mem_wen = |(ext_mem_wen & grant_q);

  assign claim_one   = (ext_claim != '0) && ((ext_claim & (ext_claim - NUM_EXT'(1))) == '0);
  assign claim_multi = (ext_claim != '0) && !claim_one;

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    cnt_d          = cnt_q;
    regw_d         = regw_q;
    rd_d           = rd_q;
    wdata_d        = wdata_q;
    wen_d          = wen_q;
    addr_d         = addr_q;
    store_d        = store_q;
    flush_pend_d   = flush_pend_q;
    ext_mem_load_d = ext_mem_load_q;
    ack_d          = '0;
    exception      = 1'b0;
    timeout        = 1'b0;
    ex_cause       = '0;
    case (state_q)
      S_IDLE: begin
        if (insn_valid && claim_one) begin
          grant_d      = ext_claim;
          cnt_d        = '0;
          flush_pend_d = 1'b0;
          state_d      = S_EXEC;
        end else if (insn_valid && claim_multi) begin
          exception = 1'b1;
          ex_cause  = ext_claim;
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (flush) begin
          grant_d = '0;
          state_d = S_IDLE;
        end else if (own_done) begin
          regw_d  = own_reg_w;
          rd_d    = own_rd;
          wdata_d = own_wdata;
          state_d = S_COMMIT;
        end else if (own_mem_req) begin
          wen_d        = own_mem_wen;
          addr_d       = own_addr;
          store_d      = own_store;
          flush_pend_d = 1'b0;
          state_d      = S_MEM;
        end else if (cnt_q == CNT_LAST) begin
          exception = 1'b1;
          timeout   = 1'b1;
          ex_cause  = grant_q;
          grant_d   = '0;
          state_d   = S_IDLE;
        end
      end
      S_MEM: begin
        cnt_d = cnt_q;
        if (flush) flush_pend_d = 1'b1;
        // a flushed transfer still runs to completion, then drops the owner silently
        if (!mem_busy) begin
          flush_pend_d = 1'b0;
          if (flush_pend_q || flush) begin
            grant_d = '0;
            state_d = S_IDLE;
          end else begin
            ext_mem_load_d = mem_load;
            ack_d          = grant_q;
            state_d        = S_EXEC;
          end
        end
      end
      default: begin
        regw_d  = 1'b0;
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= S_IDLE;
      grant_q        <= '0;
      cnt_q          <= '0;
      regw_q         <= 1'b0;
      rd_q           <= '0;
      wdata_q        <= '0;
      wen_q          <= 1'b0;
      addr_q         <= '0;
      store_q        <= '0;
      flush_pend_q   <= 1'b0;
      ext_mem_load_q <= '0;
      ack_q          <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      cnt_q          <= cnt_d;
      regw_q         <= regw_d;
      rd_q           <= rd_d;
      wdata_q        <= wdata_d;
      wen_q          <= wen_d;
      addr_q         <= addr_d;
      store_q        <= store_d;
      flush_pend_q   <= flush_pend_d;
      ext_mem_load_q <= ext_mem_load_d;
      ack_q          <= ack_d;
    end
  end

  assign grant         = grant_q;
  assign active_insn   = (state_q != S_IDLE);
  assign execute_stall = (state_q == S_EXEC) || (state_q == S_MEM);
  assign mem_ren       = (state_q == S_MEM) && !wen_q;
  assign mem_wen       = (state_q == S_MEM) && wen_q;
  assign mem_addr      = (state_q == S_MEM) ? addr_q : '0;
  assign mem_store     = (state_q == S_MEM) ? store_q : '0;
  assign ext_mem_load  = ext_mem_load_q;
  assign ext_mem_ack   = ack_q;
  assign reg_w         = (state_q == S_COMMIT) && regw_q && !flush;
  assign rsel_d        = (state_q == S_COMMIT) ? rd_q : '0;
  assign reg_wdata     = (state_q == S_COMMIT) ? wdata_q : '0;

endmodule

// File: tb/tb_risc_mgmt_ext_arbiter.sv
// Directed bench for risc_mgmt_ext_arbiter (NUM_EXT=4, WORD_W=32, TIMEOUT=64).
module tb_risc_mgmt_ext_arbiter;
  localparam int NE = 4;
  localparam int W  = 32;

  logic            CLK, RST, insn_valid, flush, mem_busy;
  logic [NE-1:0]   ext_claim, ext_done, ext_reg_w, ext_mem_req, ext_mem_wen;
  logic [5*NE-1:0] ext_rd;
  logic [W*NE-1:0] ext_wdata, ext_mem_addr, ext_mem_store;
  logic [W-1:0]    mem_load;
  logic [NE-1:0]   grant, ext_mem_ack, ex_cause;
  logic            active_insn, execute_stall, mem_ren, mem_wen, reg_w, exception, timeout;
  logic [W-1:0]    mem_addr, mem_store, ext_mem_load, reg_wdata;
  logic [4:0]      rsel_d;

  int n_cmp = 0;
  int n_err = 0;

  risc_mgmt_ext_arbiter #(.NUM_EXT(NE), .WORD_W(W), .TIMEOUT(64)) dut (
    .CLK(CLK), .RST(RST), .insn_valid(insn_valid), .flush(flush),
    .ext_claim(ext_claim), .ext_done(ext_done), .ext_reg_w(ext_reg_w), .ext_rd(ext_rd),
    .ext_wdata(ext_wdata), .ext_mem_req(ext_mem_req), .ext_mem_wen(ext_mem_wen),
    .ext_mem_addr(ext_mem_addr), .ext_mem_store(ext_mem_store), .mem_busy(mem_busy),
    .mem_load(mem_load), .grant(grant), .active_insn(active_insn),
    .execute_stall(execute_stall), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_store(mem_store), .ext_mem_load(ext_mem_load),
    .ext_mem_ack(ext_mem_ack), .reg_w(reg_w), .rsel_d(rsel_d), .reg_wdata(reg_wdata),
    .exception(exception), .ex_cause(ex_cause), .timeout(timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    insn_valid = 0; flush = 0; mem_busy = 0; mem_load = '0;
    ext_claim = '0; ext_done = '0; ext_reg_w = '0; ext_mem_req = '0; ext_mem_wen = '0;
    ext_rd = '0; ext_wdata = '0; ext_mem_addr = '0; ext_mem_store = '0;
  endtask

  task automatic test_reset();
    clr(); RST = 1;
    tick(); tick();
    RST = 0; #1;
    n_cmp++; if ({grant, ext_mem_ack, ex_cause} !== 12'h000) begin n_err++; $display("FAIL reset_vec: got %h want 000", {grant, ext_mem_ack, ex_cause}); end
    n_cmp++; if ({active_insn, execute_stall, mem_ren, mem_wen, reg_w, exception, timeout} !== 7'b0) begin n_err++; $display("FAIL reset_flags: got %b want 0000000", {active_insn, execute_stall, mem_ren, mem_wen, reg_w, exception, timeout}); end
    n_cmp++; if (ext_mem_load !== 32'h0) begin n_err++; $display("FAIL reset_load: got %h want 0", ext_mem_load); end
  endtask

  task automatic test_single_claim();
    insn_valid = 1; ext_claim = 4'b0100; #1;
    n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL single_grant_c0: got %b want 0000", grant); end
    tick(); clr(); #1;
    n_cmp++; if (grant !== 4'b0100) begin n_err++; $display("FAIL single_grant_c1: got %b want 0100", grant); end
    n_cmp++; if (execute_stall !== 1'b1) begin n_err++; $display("FAIL single_stall_c1: got %b want 1", execute_stall); end
    ext_done = 4'b0001; ext_mem_req = 4'b0010; #1;
    tick(); clr(); #1;
    n_cmp++; if (execute_stall !== 1'b1 || mem_ren !== 1'b0) begin n_err++; $display("FAIL single_foreign_ignored: got stall=%b ren=%b want 1 0", execute_stall, mem_ren); end
    tick();
    ext_done = 4'b0100; ext_reg_w = 4'b0100; ext_rd[2*5 +: 5] = 5'd5; ext_wdata[2*W +: W] = 32'hDEADBEEF; #1;
    n_cmp++; if (execute_stall !== 1'b1 || reg_w !== 1'b0) begin n_err++; $display("FAIL single_c3: got stall=%b reg_w=%b want 1 0", execute_stall, reg_w); end
    tick(); clr(); #1;
    n_cmp++; if ({reg_w, rsel_d, reg_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin n_err++; $display("FAIL single_wb: got %b %0d %h want 1 5 deadbeef", reg_w, rsel_d, reg_wdata); end
    n_cmp++; if (execute_stall !== 1'b0 || active_insn !== 1'b1) begin n_err++; $display("FAIL single_commit_flags: got stall=%b act=%b want 0 1", execute_stall, active_insn); end
    tick();
    n_cmp++; if ({active_insn, reg_w, grant} !== 6'b0) begin n_err++; $display("FAIL single_idle: got %b want 000000", {active_insn, reg_w, grant}); end
  endtask

  task automatic test_conflict();
    insn_valid = 1; ext_claim = 4'b0011; #1;
    n_cmp++; if ({exception, ex_cause, timeout} !== 6'b1_0011_0) begin n_err++; $display("FAIL conflict_exc: got %b want 100110", {exception, ex_cause, timeout}); end
    tick(); clr(); #1;
    n_cmp++; if ({exception, grant, execute_stall, active_insn} !== 7'b0) begin n_err++; $display("FAIL conflict_after: got %b want 0000000", {exception, grant, execute_stall, active_insn}); end
  endtask

  task automatic test_mem_load();
    int ren_cnt;
    ren_cnt = 0;
    insn_valid = 1; ext_claim = 4'b0010; #1;
    tick(); clr();
    ext_mem_req = 4'b0010; ext_mem_addr[1*W +: W] = 32'h100; mem_busy = 1; #1;
    n_cmp++; if (mem_ren !== 1'b0) begin n_err++; $display("FAIL load_ren_exec: got %b want 0", mem_ren); end
    tick(); ext_mem_req = '0; #1;
    n_cmp++; if (mem_addr !== 32'h100) begin n_err++; $display("FAIL load_addr: got %h want 100", mem_addr); end
    for (int k = 0; k < 3; k++) begin
      if (mem_ren === 1'b1) ren_cnt++;
      tick();
    end
    mem_busy = 0; mem_load = 32'h12345678; #1;
    if (mem_ren === 1'b1) ren_cnt++;
    n_cmp++; if (ext_mem_ack !== 4'b0000) begin n_err++; $display("FAIL load_ack_early: got %b want 0000", ext_mem_ack); end
    tick(); mem_load = '0; #1;
    n_cmp++; if (ren_cnt !== 4) begin n_err++; $display("FAIL load_ren_cycles: got %0d want 4", ren_cnt); end
    n_cmp++; if ({mem_ren, ext_mem_ack} !== 5'b0_0010) begin n_err++; $display("FAIL load_ack: got %b want 00010", {mem_ren, ext_mem_ack}); end
    n_cmp++; if (ext_mem_load !== 32'h12345678) begin n_err++; $display("FAIL load_data: got %h want 12345678", ext_mem_load); end
    n_cmp++; if (execute_stall !== 1'b1 || active_insn !== 1'b1) begin n_err++; $display("FAIL load_back_exec: got %b%b want 11", execute_stall, active_insn); end
    ext_done = 4'b0010; #1;
    tick(); clr(); #1;
    n_cmp++; if ({ext_mem_ack, reg_w, active_insn} !== 6'b0000_0_1) begin n_err++; $display("FAIL load_commit_noreg: got %b want 000001", {ext_mem_ack, reg_w, active_insn}); end
    tick();
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    insn_valid = 1; ext_claim = 4'b0001; #1;
    tick(); clr(); #1;
    for (int k = 1; k < 64; k++) begin
      if (exception !== 1'b0 || active_insn !== 1'b1) early++;
      tick();
    end
    n_cmp++; if (early !== 0) begin n_err++; $display("FAIL timeout_early: got %0d bad cycles want 0", early); end
    n_cmp++; if ({exception, timeout, ex_cause} !== 6'b11_0001) begin n_err++; $display("FAIL timeout_exc: got %b want 110001", {exception, timeout, ex_cause}); end
    tick();
    n_cmp++; if ({exception, timeout, grant, active_insn} !== 7'b0) begin n_err++; $display("FAIL timeout_after: got %b want 0000000", {exception, timeout, grant, active_insn}); end
  endtask

  task automatic test_flush_mem();
    insn_valid = 1; ext_claim = 4'b1000; #1;
    tick(); clr();
    ext_mem_req = 4'b1000; ext_mem_wen = 4'b1000; ext_mem_addr[3*W +: W] = 32'h200;
    ext_mem_store[3*W +: W] = 32'hCAFEF00D; mem_busy = 1; #1;
    tick(); ext_mem_req = '0; ext_mem_wen = '0; flush = 1; #1;
    n_cmp++; if ({mem_wen, mem_ren, mem_store} !== {2'b10, 32'hCAFEF00D}) begin n_err++; $display("FAIL flush_store: got %b %b %h want 1 0 cafef00d", mem_wen, mem_ren, mem_store); end
    tick(); flush = 0; #1;
    n_cmp++; if (mem_wen !== 1'b1 || mem_addr !== 32'h200) begin n_err++; $display("FAIL flush_held: got %b %h want 1 200", mem_wen, mem_addr); end
    tick(); mem_busy = 0; #1;
    n_cmp++; if (mem_wen !== 1'b1) begin n_err++; $display("FAIL flush_last: got %b want 1", mem_wen); end
    tick();
    n_cmp++; if ({mem_wen, ext_mem_ack, reg_w, active_insn, grant} !== 11'b0) begin n_err++; $display("FAIL flush_after: got %b want 0", {mem_wen, ext_mem_ack, reg_w, active_insn, grant}); end
  endtask

  task automatic test_back_to_back();
    insn_valid = 1; ext_claim = 4'b0100; #1;
    tick(); clr(); ext_done = 4'b0100; #1;
    tick(); clr(); insn_valid = 1; ext_claim = 4'b0001; #1;
    n_cmp++; if (grant !== 4'b0100 || active_insn !== 1'b1) begin n_err++; $display("FAIL b2b_commit: got %b %b want 0100 1", grant, active_insn); end
    tick();
    n_cmp++; if (grant !== 4'b0000 || active_insn !== 1'b0) begin n_err++; $display("FAIL b2b_gap: got %b %b want 0000 0", grant, active_insn); end
    tick(); clr(); flush = 1; #1;
    n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL b2b_second: got %b want 0001", grant); end
    tick(); clr(); #1;
    n_cmp++; if ({grant, active_insn, reg_w} !== 6'b0) begin n_err++; $display("FAIL b2b_flush_exec: got %b want 000000", {grant, active_insn, reg_w}); end
  endtask

  task automatic test_reset_commit();
    insn_valid = 1; ext_claim = 4'b0001; #1;
    tick(); clr();
    ext_done = 4'b0001; ext_reg_w = 4'b0001; ext_rd[4:0] = 5'd7; ext_wdata[W-1:0] = 32'h55; #1;
    tick(); clr(); #1;
    n_cmp++; if (reg_w !== 1'b1 || rsel_d !== 5'd7) begin n_err++; $display("FAIL rstc_pre: got %b %0d want 1 7", reg_w, rsel_d); end
    RST = 1; #1;
    tick(); RST = 0; #1;
    n_cmp++; if ({reg_w, rsel_d, reg_wdata, grant, active_insn, execute_stall} !== 45'b0) begin n_err++; $display("FAIL rstc_after: got %h want 0", {reg_w, rsel_d, reg_wdata, grant, active_insn, execute_stall}); end
    n_cmp++; if (ext_mem_load !== 32'h0) begin n_err++; $display("FAIL rstc_load: got %h want 0", ext_mem_load); end
  endtask

  task automatic test_reset_mem();
    insn_valid = 1; ext_claim = 4'b0001; #1;
    tick(); clr(); ext_mem_req = 4'b0001; ext_mem_addr[W-1:0] = 32'h40; mem_busy = 1; #1;
    tick(); ext_mem_req = '0; #1;
    n_cmp++; if (mem_ren !== 1'b1) begin n_err++; $display("FAIL rstm_ren: got %b want 1", mem_ren); end
    RST = 1; #1;
    tick(); RST = 0; #1;
    n_cmp++; if ({mem_ren, mem_wen, mem_addr, active_insn} !== 35'b0) begin n_err++; $display("FAIL rstm_drop: got %h want 0", {mem_ren, mem_wen, mem_addr, active_insn}); end
    mem_busy = 0; mem_load = 32'hFFFF0000; #1;
    tick();
    n_cmp++; if (ext_mem_ack !== 4'b0000 || ext_mem_load !== 32'h0) begin n_err++; $display("FAIL rstm_noack: got %b %h want 0000 0", ext_mem_ack, ext_mem_load); end
  endtask

  initial begin
    RST = 1;
    clr();
    test_reset();
    test_single_claim();
    test_conflict();
    test_mem_load();
    test_timeout();
    test_flush_mem();
    test_back_to_back();
    test_reset_commit();
    test_reset_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
